// File: rtl/mmio_uart_tx_pkg.sv
// Shared register map, status field positions and transmit FSM states
// for the memory-mapped UART transmitter.
package mmio_uart_tx_pkg;

    localparam logic [2:0] UART_TXDATA_OFFSET = 3'h0;
    localparam logic [2:0] UART_STATUS_OFFSET = 3'h4;

    localparam int unsigned STATUS_BUSY_BIT  = 0;
    localparam int unsigned STATUS_FULL_BIT  = 1;
    localparam int unsigned STATUS_EMPTY_BIT = 2;
    localparam int unsigned STATUS_COUNT_LSB = 4;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count; pointers wrap modulo DEPTH
// (DEPTH must be a power of two). Head entry is presented combinationally.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign data_out = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA store port feeding a FIFO,
// STATUS load port, and a START/DATA/STOP serialiser.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_1000,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] address,
    input  logic [31:0] input_data,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic [31:0] output_data,
    output logic        stall,
    output logic        tx
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);

    logic          selected;
    logic [2:0]    offset;
    logic          txdata_store;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_head;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status_word;
    logic          unused_data_bits;

    uart_state_t   state, state_nxt;
    logic [BW-1:0] baud_cnt, baud_nxt;
    logic [7:0]    shift_reg, shift_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;

    assign selected     = (address[31:3] == BASE_ADDRESS[31:3]);
    assign offset       = address[2:0];
    assign txdata_store = selected & mem_write & (offset == UART_TXDATA_OFFSET);
    // full is the registered flag, so a same-cycle pop cannot unblock the store
    assign stall        = txdata_store & fifo_full;
    assign fifo_push    = txdata_store & ~fifo_full;
    assign unused_data_bits = ^input_data[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (fifo_push),
        .pop      (fifo_pop),
        .data_in  (input_data[7:0]),
        .data_out (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        status_word = '0;
        status_word[STATUS_BUSY_BIT]        = (state != UART_IDLE);
        status_word[STATUS_FULL_BIT]        = fifo_full;
        status_word[STATUS_EMPTY_BIT]       = fifo_empty;
        status_word[STATUS_COUNT_LSB +: 4]  = 4'(fifo_count);
    end

    assign output_data = (selected && mem_read && offset == UART_STATUS_OFFSET)
                         ? status_word : '0;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= UART_IDLE;
            baud_cnt  <= '0;
            shift_reg <= '0;
            bit_idx   <= '0;
        end else begin
            state     <= state_nxt;
            baud_cnt  <= baud_nxt;
            shift_reg <= shift_nxt;
            bit_idx   <= bit_idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        baud_nxt    = baud_cnt;
        shift_nxt   = shift_reg;
        bit_idx_nxt = bit_idx;
        fifo_pop    = 1'b0;
        tx          = 1'b1;
        case (state)
            UART_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_nxt = fifo_head;
                    baud_nxt  = BAUD_RELOAD;
                    state_nxt = UART_START;
                end
            end
            UART_START: begin
                tx = 1'b0;
                if (baud_cnt == '0) begin
                    baud_nxt    = BAUD_RELOAD;
                    bit_idx_nxt = '0;
                    state_nxt   = UART_DATA;
                end else begin
                    baud_nxt = baud_cnt - 1'b1;
                end
            end
            UART_DATA: begin
                tx = shift_reg[0];
                if (baud_cnt == '0) begin
                    baud_nxt    = BAUD_RELOAD;
                    shift_nxt   = {1'b0, shift_reg[7:1]};
                    bit_idx_nxt = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_nxt = UART_STOP;
                end else begin
                    baud_nxt = baud_cnt - 1'b1;
                end
            end
            UART_STOP: begin
                if (baud_cnt == '0) state_nxt = UART_IDLE;
                else                baud_nxt  = baud_cnt - 1'b1;
            end
            default: state_nxt = UART_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4, depth 4).
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] address;
    logic [31:0] input_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] output_data;
    logic        stall;
    logic        tx;

    int checks   = 0;
    int failures = 0;

    logic txlog [0:4095];
    int   cyc = 0;

    mmio_uart_tx #(
        .BASE_ADDRESS (BASE),
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .address     (address),
        .input_data  (input_data),
        .mem_write   (mem_write),
        .mem_read    (mem_read),
        .output_data (output_data),
        .stall       (stall),
        .tx          (tx)
    );

    always #5 clock = ~clock;

    // txlog[i] holds tx as seen just after posedge number i
    always @(posedge clock) begin
        #2;
        if (cyc < 4096) txlog[cyc] = tx;
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Expected line level k cycles after the accepting edge (k = 1..40)
    function automatic logic exp_tx(input logic [7:0] b, input int k);
        if (k <= 4)       return 1'b0;
        else if (k <= 36) return b[(k - 5) / 4];
        else              return 1'b1;
    endfunction

    logic [7:0] bytes6 [6];
    logic [7:0] bytes4 [4];
    int mism;
    int low_seen;
    int stall_cycles;
    int start_idx;
    int idx;
    logic e;

    initial begin
        bytes6 = '{8'h11, 8'hA5, 8'h3C, 8'h80, 8'h01, 8'hE7};
        bytes4 = '{8'hC3, 8'h0F, 8'hF0, 8'h81};
        reset_n = 1'b0; address = '0; input_data = '0;
        mem_write = 1'b0; mem_read = 1'b0;
        step(); step();
        reset_n = 1'b1;
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_output_data", output_data, 32'h0);

        low_seen = 0;
        repeat (20) begin
            step();
            if (tx !== 1'b1) low_seen++;
        end
        chk("idle_tx_high", low_seen, 0);
        address = BASE + 32'd4; mem_read = 1'b1; #1;
        chk("status_after_reset", output_data, 32'h0000_0004);
        chk("read_no_stall", 32'(stall), 32'd0);
        step(); mem_read = 1'b0;

        // Single 0x55 frame, cycle-by-cycle
        address = BASE; input_data = 32'hFFFF_FF55; mem_write = 1'b1; #1;
        chk("store55_no_stall", 32'(stall), 32'd0);
        step();
        mem_write = 1'b0; input_data = '0;
        chk("tx_high_at_accept", 32'(tx), 32'd1);
        mism = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (tx !== exp_tx(8'h55, k)) mism++;
            if (k == 1) chk("first_start_bit", 32'(tx), 32'd0);
            if (k == 20) begin
                address = BASE + 32'd4; mem_read = 1'b1; #1;
                chk("status_busy_mid_frame", output_data, 32'h0000_0001 | 32'h0000_0004);
                mem_read = 1'b0;
            end
        end
        chk("frame_55_bits", mism, 0);
        step();
        address = BASE + 32'd4; mem_read = 1'b1; #1;
        chk("status_idle_after_frame", output_data, 32'h0000_0004);
        step(); mem_read = 1'b0;

        // Six back-to-back stores into a depth-4 FIFO
        mism = 0;
        start_idx = 0;
        for (int i = 0; i < 5; i++) begin
            address = BASE; input_data = {24'h0, bytes6[i]}; mem_write = 1'b1; #1;
            if (stall !== 1'b0) mism++;
            step();
            if (i == 0) start_idx = cyc - 1;
        end
        chk("first5_no_stall", mism, 0);
        input_data = {24'h0, bytes6[5]}; #1;
        stall_cycles = 0;
        while (stall === 1'b1 && stall_cycles < 100) begin
            stall_cycles++;
            step(); #1;
        end
        chk("sixth_stall_cycles", stall_cycles, 38);
        chk("sixth_released", 32'(stall), 32'd0);
        step();
        mem_write = 1'b0;
        address = BASE + 32'd4; mem_read = 1'b1; #1;
        chk("status_full_busy", output_data, 32'h0000_0043);
        address = 32'h0000_2004; #1;
        chk("oow_read_data", output_data, 32'h0);
        chk("oow_read_stall", 32'(stall), 32'd0);
        mem_read = 1'b0; address = 32'h0000_2000; mem_write = 1'b1; #1;
        chk("oow_write_full_no_stall", 32'(stall), 32'd0);
        step();
        mem_write = 1'b0;

        while (cyc <= start_idx + 41 * 6 + 3) step();
        for (int j = 0; j < 6; j++) begin
            mism = 0;
            for (int k = 1; k <= 41; k++) begin
                idx = start_idx + 41 * j + k;
                e = (k == 41) ? 1'b1 : exp_tx(bytes6[j], k);
                if (txlog[idx] !== e) mism++;
            end
            chk($sformatf("frame6_%0d", j), mism, 0);
        end
        address = BASE + 32'd4; mem_read = 1'b1; #1;
        chk("status_empty_after_burst", output_data, 32'h0000_0004);
        step(); mem_read = 1'b0;

        // Stores to STATUS and outside the window do nothing
        address = BASE + 32'd4; input_data = 32'h77; mem_write = 1'b1; #1;
        chk("store_status_no_stall", 32'(stall), 32'd0);
        step();
        address = BASE + 32'd8; #1;
        chk("store_base8_no_stall", 32'(stall), 32'd0);
        step();
        mem_write = 1'b0;
        low_seen = 0;
        repeat (10) begin
            step();
            if (tx !== 1'b1) low_seen++;
        end
        chk("ignored_store_tx_high", low_seen, 0);
        address = BASE + 32'd4; mem_read = 1'b1; #1;
        chk("ignored_store_status", output_data, 32'h0000_0004);
        step(); mem_read = 1'b0;

        // Reset mid-DATA with three bytes queued and a store in flight
        for (int i = 0; i < 4; i++) begin
            address = BASE; input_data = {24'h0, bytes4[i]}; mem_write = 1'b1;
            step();
        end
        mem_write = 1'b0;
        repeat (8) step();
        address = BASE + 32'd4; mem_read = 1'b1; #1;
        chk("status_before_reset", output_data, 32'h0000_0031);
        mem_read = 1'b0;
        reset_n = 1'b0; address = BASE; input_data = 32'h99; mem_write = 1'b1;
        step();
        reset_n = 1'b1; mem_write = 1'b0;
        chk("tx_high_after_reset", 32'(tx), 32'd1);
        address = BASE + 32'd4; mem_read = 1'b1; #1;
        chk("status_after_midframe_reset", output_data, 32'h0000_0004);
        mem_read = 1'b0;
        low_seen = 0;
        repeat (60) begin
            step();
            if (tx !== 1'b1) low_seen++;
        end
        chk("no_frames_after_reset", low_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter that responds on the data-side memory port. It sits behind the memory controller's peripheral address window. The core writes bytes into a small TX FIFO through ordinary stores and polls a status register through ordinary loads. The block serialises the bytes as 8N1 frames on a single output pin, and it stalls the requesting stage with the same stall handshake the memory controller uses for L1 refills.

## Interface
Parameters:
- BASE_ADDRESS, 32'h0000_1000, byte address of the register window (two words).
- CLKS_PER_BIT, 4, clock cycles per UART bit (≥2).
- FIFO_DEPTH, 4, TX FIFO entries (power of two, ≥2).

Ports:
- clock  input  1  CPU clock. Everything is registered on the posedge.
- reset_n  input  1  Synchronous, active-low reset.
- address  input  32  Byte address from the data-side request.
- input_data  input  32  Store data; only bits [7:0] are used.
- mem_write  input  1  Store request, level, held while stall is high.
- mem_read  input  1  Load request.
- output_data  output  32  Load data. Combinational from the registers.
- stall  output  1  Request not accepted this cycle; the requester holds its inputs.
- tx  output  1  Serial line; idles high.

## Operation
- Selected = address[31:3] == BASE_ADDRESS[31:3]. Unselected requests are ignored: output_data = 0 and stall = 0.
- Offset 0 is TXDATA (write-only). A store with the FIFO not full pushes input_data[7:0]. Loads return 0.
- Offset 4 is STATUS (read-only). The field layout is:
  - [0] busy: FSM is not in IDLE.
  - [1] full.
  - [2] empty.
  - [7:4] FIFO count.
  - All other bits are 0.
  - Stores to STATUS are ignored and do not stall.
- stall = selected & mem_write & offset 0 & full. Full is evaluated before any same-cycle pop, so a store to a full FIFO always costs at least one stall cycle.
- Reads never stall.
- Transmit FSM has four states: IDLE, START, DATA, STOP.
  - IDLE: tx = 1. If the FIFO is non-empty, pop the head into the shift register, load the baud counter with CLKS_PER_BIT-1 and go to START.
  - START: tx = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0], LSB first. Each time the baud counter expires, shift right and increment the index. After bit 7 expires, go to STOP.
  - STOP: tx = 1 for CLKS_PER_BIT cycles, then go to IDLE.
- Frames are back to back: IDLE lasts exactly one cycle when the FIFO is non-empty, so the gap between frames is one idle-high cycle.
- Counter widths:
  - Baud counter is $clog2(CLKS_PER_BIT) bits and counts down.
  - FIFO count is $clog2(FIFO_DEPTH)+1 bits.
  - FIFO pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: tx = 1, stall = 0, output_data = 0, FSM = IDLE, FIFO empty, counters 0.
- Reset takes precedence over everything:
  - If asserted mid-frame, tx is 1 on the next cycle.
  - The FIFO is flushed.
  - An in-flight store is dropped.
- Latency from an accepted store at edge N (FIFO empty, FSM IDLE):
  - Pop and move to START at edge N+1.
  - tx = 0 from edge N+1.
- One frame takes 10·CLKS_PER_BIT cycles in START/DATA/STOP, plus one IDLE cycle.
- Push and pop in the same cycle (not full): count is unchanged and both take effect.
- Stall release: a pop at edge M clears full at M. The held store is accepted at edge M+1.
- STATUS reflects register state after the last edge; a same-cycle push is not visible.

## Structure
- Shared defines header holds:
  - `UART_TXDATA_OFFSET (3'h0) and `UART_STATUS_OFFSET (3'h4).
  - `UART_IDLE/START/DATA/STOP state encodings (2 bits).
  - STATUS bit positions.
- One sub-module, sync_fifo:
  - Parameterised width and depth.
  - Ports: push, pop, data in/out, full, empty, count, with synchronous active-low reset.
- Baud counter, shift register and FSM live in mmio_uart_tx.

## Test plan
- Reset then idle 20 cycles → tx = 1, stall = 0, STATUS read = 32'h0000_0004 (empty).
- Store 0x55 to BASE (CLKS_PER_BIT = 4) → tx low for cycles 1–4. Data bits 1,0,1,0,1,0,1,0 for 4 cycles each on cycles 5–36. High for cycles 37–40. busy = 0 at cycle 41.
- Store 6 bytes back to back (depth 4):
  - First store is popped at once; the next 4 fill the FIFO.
  - Sixth store: stall high until the first frame ends, then accepted the cycle after the pop.
  - All 6 bytes appear in order with one-cycle gaps.
- While transmitting, read STATUS → busy = 1, count matches the number of stores minus pops. Out-of-window read → output_data = 0, stall = 0.
- Store to STATUS and to BASE+8 → no push, no stall, tx stays high.
- Assert reset_n = 0 for one cycle mid-DATA with 3 bytes queued → tx = 1 next cycle, STATUS = empty, and no further frames are sent.
